// File: rtl/kf_pkg.sv
// Shared types and defaults for the Kalman frame sequencer slice.
package kf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    WB,
    OUT
  } kf_state_e;

  localparam int KF_N       = 20;
  localparam int KF_FRAC    = 10;
  localparam int KF_TIMEOUT = 38;

  // Channel index width; a single channel still needs one index bit.
  function automatic int kf_chw(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/kf_chan_state_mem.sv
// Per-channel posterior store: NCH entries of {x10, x00}, one async read
// port, one sync write port, synchronous clear that beats any write.
module kf_chan_state_mem
  import kf_pkg::*;
#(
  parameter int N   = KF_N,
  parameter int NCH = 4,
  parameter int CHW = kf_chw(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic [CHW-1:0] rd_ch,
  output logic [N-1:0]   rd_x00,
  output logic [N-1:0]   rd_x10,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [N-1:0]   wr_x00,
  input  logic [N-1:0]   wr_x10
);

  logic [2*N-1:0] mem [NCH];

  // Register file update: reset and clear zero everything, else one write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < NCH; i++) mem[i] <= '0;
    end else if (wr_en && (int'(wr_ch) < NCH)) begin
      mem[wr_ch] <= {wr_x10, wr_x00};
    end
  end

  // Combinational read; out-of-range channels read as zero.
  always_comb begin
    rd_x00 = '0;
    rd_x10 = '0;
    if (int'(rd_ch) < NCH) begin
      {rd_x10, rd_x00} = mem[rd_ch];
    end
  end

endmodule

// File: rtl/kf_frame_sequencer.sv
// Time-multiplexes NCH Kalman filter channels over one core: accepts a
// sample, launches a watchdog-guarded frame, writes the posterior back as
// the channel's next prior and presents the result on a valid/ready port.
module kf_frame_sequencer
  import kf_pkg::*;
#(
  parameter int N       = KF_N,
  parameter int FRAC    = KF_FRAC,
  parameter int NCH     = 4,
  parameter int CHW     = kf_chw(NCH),
  parameter int TIMEOUT = KF_TIMEOUT,
  parameter int LATW    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [CHW-1:0]  s_ch,
  input  logic [N-1:0]    s_u00,
  input  logic [N-1:0]    s_u10,
  input  logic [N-1:0]    s_z00,
  input  logic [N-1:0]    s_z10,
  output logic            kf_start,
  output logic [N-1:0]    kf_x00_prev,
  output logic [N-1:0]    kf_x10_prev,
  output logic [N-1:0]    kf_u00,
  output logic [N-1:0]    kf_u10,
  output logic [N-1:0]    kf_z00,
  output logic [N-1:0]    kf_z10,
  input  logic            kf_done,
  input  logic [N-1:0]    kf_x00_post,
  input  logic [N-1:0]    kf_x10_post,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [CHW-1:0]  m_ch,
  output logic [N-1:0]    m_x00,
  output logic [N-1:0]    m_x10,
  output logic            m_timeout,
  output logic [LATW-1:0] last_lat,
  output logic            err_timeout,
  output logic            err_badch,
  output logic            err_spurious,
  output logic [31:0]     frame_cnt
);

  if (FRAC < 0 || FRAC >= N) begin : g_bad_frac
    $error("kf_frame_sequencer: FRAC must lie in [0, N)");
  end
  if (NCH < 1 || NCH > 256 || TIMEOUT < 1 || TIMEOUT >= (1 << LATW)) begin : g_bad_cfg
    $error("kf_frame_sequencer: NCH out of 1..256 or TIMEOUT does not fit LATW");
  end

  kf_state_e       state, state_nxt;
  logic [LATW-1:0] cnt;
  logic [LATW-1:0] cnt_inc;
  logic            wd_expire;
  logic            accept;
  logic            ch_ok;
  logic            pend_clr;
  logic            wr_en;
  logic [N-1:0]    rd_x00, rd_x10;

  assign accept    = s_valid && s_ready;
  assign ch_ok     = (int'(s_ch) < NCH);
  assign cnt_inc   = cnt + LATW'(1);
  assign wd_expire = (cnt_inc == LATW'(TIMEOUT));
  // Timed-out frames and frames overtaken by a clear leave the store alone.
  assign wr_en     = (state == WB) && !m_timeout && !pend_clr && !clear;

  kf_chan_state_mem #(
    .N   (N),
    .NCH (NCH),
    .CHW (CHW)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .rd_ch  (s_ch),
    .rd_x00 (rd_x00),
    .rd_x10 (rd_x10),
    .wr_en  (wr_en),
    .wr_ch  (m_ch),
    .wr_x00 (m_x00),
    .wr_x10 (m_x10)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && ch_ok)      state_nxt = LAUNCH;
      LAUNCH:                            state_nxt = WAIT;
      WAIT:    if (kf_done || wd_expire) state_nxt = WB;
      WB:                                state_nxt = OUT;
      OUT:     if (m_ready)              state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    s_ready  = (state == IDLE) && !clear;
    kf_start = (state == LAUNCH);
    m_valid  = (state == OUT);
  end

  // Frame datapath: operand capture, watchdog counter, result capture.
  // The prior is read at accept time so the core operands are registered
  // before LAUNCH and held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kf_x00_prev <= '0;
      kf_x10_prev <= '0;
      kf_u00      <= '0;
      kf_u10      <= '0;
      kf_z00      <= '0;
      kf_z10      <= '0;
      cnt         <= '0;
      m_ch        <= '0;
      m_x00       <= '0;
      m_x10       <= '0;
      m_timeout   <= 1'b0;
      last_lat    <= '0;
      frame_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && ch_ok) begin
            m_ch        <= s_ch;
            kf_u00      <= s_u00;
            kf_u10      <= s_u10;
            kf_z00      <= s_z00;
            kf_z10      <= s_z10;
            kf_x00_prev <= rd_x00;
            kf_x10_prev <= rd_x10;
          end
        end
        LAUNCH: cnt <= '0;
        WAIT: begin
          cnt <= cnt_inc;
          if (kf_done) begin
            m_x00     <= kf_x00_post;
            m_x10     <= kf_x10_post;
            m_timeout <= 1'b0;
            last_lat  <= cnt_inc;
          end else if (wd_expire) begin
            m_x00     <= kf_x00_prev;
            m_x10     <= kf_x10_prev;
            m_timeout <= 1'b1;
            last_lat  <= LATW'(TIMEOUT);
          end
        end
        WB:      frame_cnt <= frame_cnt + 32'd1;
        default: ;
      endcase
    end
  end

  // Pending clear: remembers a clear seen while a frame was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       pend_clr <= 1'b0;
    else if (clear && (state == LAUNCH || state == WAIT)) pend_clr <= 1'b1;
    else if (state == WB)                             pend_clr <= 1'b0;
  end

  // Sticky error flags, cleared by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout  <= 1'b0;
      err_badch    <= 1'b0;
      err_spurious <= 1'b0;
    end else if (clear) begin
      err_timeout  <= 1'b0;
      err_badch    <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (state == IDLE && accept && !ch_ok)          err_badch    <= 1'b1;
      if (state == WAIT && !kf_done && wd_expire)     err_timeout  <= 1'b1;
      if (kf_done && state != WAIT)                   err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kf_frame_sequencer.sv
// Bench for kf_frame_sequencer: directed frames against a mock core, a
// transaction-level channel-state model and a per-cycle result checker.
module tb_kf_frame_sequencer;
  import kf_pkg::*;

  localparam int NCH = 5;

  logic        clk, rst_n, clear;
  logic        s_valid, s_ready;
  logic [2:0]  s_ch;
  logic [19:0] s_u00, s_u10, s_z00, s_z10;
  logic        kf_start, kf_done;
  logic [19:0] kf_x00_prev, kf_x10_prev, kf_u00, kf_u10, kf_z00, kf_z10;
  logic [19:0] kf_x00_post, kf_x10_post;
  logic        m_valid, m_ready, m_timeout;
  logic [2:0]  m_ch;
  logic [19:0] m_x00, m_x10;
  logic [7:0]  last_lat;
  logic        err_timeout, err_badch, err_spurious;
  logic [31:0] frame_cnt;

  logic        mock_done, stray_done;
  int          mock_delay;
  assign kf_done = mock_done | stray_done;

  kf_frame_sequencer #(.NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch),
    .s_u00(s_u00), .s_u10(s_u10), .s_z00(s_z00), .s_z10(s_z10),
    .kf_start(kf_start), .kf_x00_prev(kf_x00_prev), .kf_x10_prev(kf_x10_prev),
    .kf_u00(kf_u00), .kf_u10(kf_u10), .kf_z00(kf_z00), .kf_z10(kf_z10),
    .kf_done(kf_done), .kf_x00_post(kf_x00_post), .kf_x10_post(kf_x10_post),
    .m_valid(m_valid), .m_ready(m_ready), .m_ch(m_ch),
    .m_x00(m_x00), .m_x10(m_x10), .m_timeout(m_timeout), .last_lat(last_lat),
    .err_timeout(err_timeout), .err_badch(err_badch), .err_spurious(err_spurious),
    .frame_cnt(frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: channel priors, expected results and expected launch operands.
  typedef struct {
    logic [2:0]  ch;
    logic [19:0] x00, x10;
    logic        to;
    logic [7:0]  lat;
    logic        wb;
  } res_t;

  res_t        exp_q[$];
  logic [19:0] mdl00 [NCH];
  logic [19:0] mdl10 [NCH];
  logic [19:0] l_p00, l_p10, l_u00, l_u10, l_z00, l_z10;
  int          model_frames = 0;

  // Mock core: done pulse sampled mock_delay edges after kf_start; 0 = never.
  initial begin
    mock_done = 1'b0;
    forever begin
      @(negedge clk);
      if (kf_start && mock_delay > 0) begin
        repeat (mock_delay) @(posedge clk);
        #1 mock_done = 1'b1;
        @(posedge clk);
        #1 mock_done = 1'b0;
      end
    end
  end

  // Compare process: launch operands and every cycle of an offered result.
  initial begin
    res_t cur;
    bit   in_out = 1'b0;
    bit   prev_start = 1'b0;
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      if (kf_start) begin
        chk("start_single_cycle", {31'd0, prev_start}, 32'd0);
        chk("launch_x00_prev", kf_x00_prev, l_p00);
        chk("launch_x10_prev", kf_x10_prev, l_p10);
        chk("launch_u00", kf_u00, l_u00);
        chk("launch_u10", kf_u10, l_u10);
        chk("launch_z00", kf_z00, l_z00);
        chk("launch_z10", kf_z10, l_z10);
      end
      if (m_valid) begin
        if (!in_out) begin
          in_out = 1'b1;
          model_frames++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got m_valid=1 expected no result");
          end else begin
            cur = exp_q.pop_front();
            if (cur.wb) begin
              mdl00[cur.ch] = cur.x00;
              mdl10[cur.ch] = cur.x10;
            end
          end
        end
        chk("res_ch", m_ch, cur.ch);
        chk("res_x00", m_x00, cur.x00);
        chk("res_x10", m_x10, cur.x10);
        chk("res_timeout", m_timeout, cur.to);
        chk("res_lat", last_lat, cur.lat);
        chk("res_frame_cnt", frame_cnt, model_frames);
        chk("out_s_ready", s_ready, 1'b0);
        chk("out_kf_start", kf_start, 1'b0);
      end else begin
        in_out = 1'b0;
      end
      prev_start = kf_start;
    end
  end

  // One complete frame: accept, mock core, optional mid-frame clear, drain.
  task automatic send(input logic [2:0] ch, input logic [19:0] u00, u10, z00, z10,
                      input int delay, input logic [19:0] p00, p10,
                      input bit clr_mid, input int hold);
    res_t r;
    int   n;
    l_p00 = mdl00[ch];  l_p10 = mdl10[ch];
    l_u00 = u00; l_u10 = u10; l_z00 = z00; l_z10 = z10;
    r.ch = ch;
    if (delay == 0 || delay > 38) begin
      r.to = 1'b1; r.x00 = l_p00; r.x10 = l_p10; r.lat = 8'd38; r.wb = 1'b0;
    end else begin
      r.to = 1'b0; r.x00 = p00; r.x10 = p10; r.lat = 8'(delay); r.wb = !clr_mid;
    end
    exp_q.push_back(r);
    mock_delay = delay;
    kf_x00_post = p00;
    kf_x10_post = p10;
    chk("idle_s_ready", s_ready, 1'b1);
    s_valid = 1'b1; s_ch = ch;
    s_u00 = u00; s_u10 = u10; s_z00 = z00; s_z10 = z10;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("start_after_accept", kf_start, 1'b1);
    @(posedge clk); #1;
    chk("start_dropped", kf_start, 1'b0);
    n = 0;
    if (clr_mid) begin
      repeat (5) begin @(posedge clk); #1; n++; end
      clear = 1'b1;
      @(posedge clk); #1; n++;
      clear = 1'b0;
      for (int i = 0; i < NCH; i++) begin mdl00[i] = '0; mdl10[i] = '0; end
    end
    while (!m_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("result_latency", n, r.lat + 1);
    repeat (hold) @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("handshake_m_valid", m_valid, 1'b0);
    chk("handshake_s_ready", s_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_ch = '0;
    s_u00 = '0; s_u10 = '0; s_z00 = '0; s_z10 = '0;
    m_ready = 1'b0; stray_done = 1'b0; mock_delay = 0;
    kf_x00_post = '0; kf_x10_post = '0;
    for (int i = 0; i < NCH; i++) begin mdl00[i] = '0; mdl10[i] = '0; end

    #22;
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_kf_start", kf_start, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_frame_cnt", frame_cnt, 32'd0);
    chk("rst_errs", {err_timeout, err_badch, err_spurious}, 3'b000);
    chk("rst_kf_ops", {kf_x00_prev, kf_x10_prev, kf_u00, kf_u10, kf_z00, kf_z10} == '0, 1'b1);
    chk("rst_m_data", {m_ch, m_x00, m_x10, m_timeout, last_lat} == '0, 1'b1);

    // Nominal frame and second frame on the same channel.
    send(3'd0, 20'h00400, 20'h00011, 20'h00022, 20'h00033, 34, 20'h00123, 20'hFFF00, 0, 0);
    chk("f1_x00", m_x00, 20'h00123);
    chk("f1_x10", m_x10, 20'hFFF00);
    chk("f1_lat", last_lat, 8'd34);
    chk("f1_prior", {kf_x00_prev, kf_x10_prev}, 40'd0);
    send(3'd0, 20'h00401, 20'h00012, 20'h00023, 20'h00034, 34, 20'h00456, 20'h00789, 0, 0);
    chk("f2_prior00", kf_x00_prev, 20'h00123);
    chk("f2_prior10", kf_x10_prev, 20'hFFF00);

    // Interleave channels.
    send(3'd1, 20'h01000, 20'h02000, 20'h03000, 20'h04000, 30, 20'h11111, 20'h22222, 0, 0);
    chk("f3_prior", {kf_x00_prev, kf_x10_prev}, 40'd0);
    chk("f3_lat", last_lat, 8'd30);
    send(3'd0, 20'h00402, 20'h00013, 20'h00024, 20'h00035, 34, 20'h33333, 20'h44444, 0, 0);
    chk("f4_prior00", kf_x00_prev, 20'h00456);
    chk("f4_prior10", kf_x10_prev, 20'h00789);
    chk("f4_frame_cnt", frame_cnt, 32'd4);

    // Watchdog expiry with a stalled consumer, then done on the last cycle.
    send(3'd1, 20'h05000, 20'h06000, 20'h07000, 20'h08000, 0, 20'h99999, 20'h99999, 0, 10);
    chk("to_flag", m_timeout, 1'b1);
    chk("to_x00", m_x00, 20'h11111);
    chk("to_lat", last_lat, 8'd38);
    chk("to_err", err_timeout, 1'b1);
    chk("to_frame_cnt", frame_cnt, 32'd5);
    send(3'd1, 20'h05001, 20'h06001, 20'h07001, 20'h08001, 38, 20'h0AAAA, 20'h0BBBB, 0, 0);
    chk("edge_prior00", kf_x00_prev, 20'h11111);
    chk("edge_timeout", m_timeout, 1'b0);
    chk("edge_lat", last_lat, 8'd38);
    chk("edge_x00", m_x00, 20'h0AAAA);

    // Clear during WAIT: result still produced, writeback suppressed.
    send(3'd2, 20'h00001, 20'h00002, 20'h00003, 20'h00004, 34, 20'h55555, 20'h66666, 1, 0);
    chk("clr_x00", m_x00, 20'h55555);
    chk("clr_err_cleared", err_timeout, 1'b0);
    send(3'd2, 20'h00005, 20'h00006, 20'h00007, 20'h00008, 10, 20'h77777, 20'h88888, 0, 0);
    chk("clr_next_prior", {kf_x00_prev, kf_x10_prev}, 40'd0);

    // Out-of-range channel is dropped; highest valid channel still works.
    s_valid = 1'b1; s_ch = 3'd5;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("badch_no_start", kf_start, 1'b0);
    chk("badch_err", err_badch, 1'b1);
    chk("badch_s_ready", s_ready, 1'b1);
    send(3'd4, 20'h0F000, 20'h0E000, 20'h0D000, 20'h0C000, 20, 20'hABCDE, 20'h13579, 0, 0);
    chk("ch4_prior", {kf_x00_prev, kf_x10_prev}, 40'd0);

    // Stray done while idle.
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    chk("spurious_err", err_spurious, 1'b1);
    chk("spurious_no_result", m_valid, 1'b0);

    // Clear while idle blocks acceptance and wipes the sticky flags.
    clear = 1'b1;
    #1 chk("clear_s_ready", s_ready, 1'b0);
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_errs", {err_timeout, err_badch, err_spurious}, 3'b000);
    chk("queue_drained", exp_q.size(), 32'd0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kf_frame_sequencer.md
Name: kf_frame_sequencer

Overview:
Closed-loop frame controller for the 2-state Kalman core (top_kf). It time-multiplexes NCH independent filter channels over one core and keeps per-channel posterior state (x00, x10) on chip. For each input sample it launches a start/done frame, guards it with a watchdog, writes the posterior back as that channel's next prior, and streams the result out. Matrix, noise and beta configuration wire directly to the core, outside this block.

Parameters:
N, 20, fixed-point word width Q(N,FRAC), signed
FRAC, 10, fractional bits; passed through to the package only, no arithmetic performed here
NCH, 4, number of filter channels, 1..256
CHW, max(1,$clog2(NCH)), channel index width (derived)
TIMEOUT, 38, watchdog limit in cycles; the nominal core frame is 34 cycles plus a margin of 4
LATW, 8, width of the latency counter; must hold TIMEOUT

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous; zeroes all channel state
s_valid  in  1  input sample valid
s_ready  out  1  sequencer can accept a sample
s_ch  in  CHW  channel index of the sample
s_u00, s_u10  in  N each  control input u
s_z00, s_z10  in  N each  measurement z
kf_start  out  1  one-cycle start pulse to the core
kf_x00_prev, kf_x10_prev  out  N each  prior state to the core
kf_u00, kf_u10, kf_z00, kf_z10  out  N each  operands to the core
kf_done  in  1  core done, level
kf_x00_post, kf_x10_post  in  N each  core posterior
m_valid  out  1  result valid
m_ready  in  1  result accepted by the consumer
m_ch  out  CHW  channel of the result
m_x00, m_x10  out  N each  result state
m_timeout  out  1  result is a timeout passthrough
last_lat  out  LATW  measured latency of the last completed frame
err_timeout, err_badch, err_spurious  out  1 each  sticky error flags
frame_cnt  out  32  count of completed frames, wraps

Behaviour:
- Reset: all outputs 0 except s_ready=1; FSM enters IDLE; channel state memory is all zero; sticky flags are cleared.
- FSM states: IDLE, LAUNCH, WAIT, WB, OUT.
- IDLE: s_ready=1 (0 while clear=1). An accept is s_valid & s_ready at an edge; it registers ch, u and z.
  - If s_ch >= NCH: drop the sample, set err_badch, stay in IDLE.
  - Otherwise go to LAUNCH and read the prior for that channel.
- LAUNCH: exactly one cycle with kf_start=1; latency counter loads 0; go to WAIT. kf_* operands are registered and stay stable from LAUNCH until the FSM leaves WAIT.
- WAIT: the counter increments every cycle.
  - kf_done=1 → normal completion. last_lat = number of edges from the edge that sampled kf_start high to the edge that sampled kf_done high (34 for a nominal core). Capture the posterior.
  - Counter reaches TIMEOUT with kf_done=0 → timeout. Result = prior, m_timeout=1, set err_timeout, last_lat=TIMEOUT.
  - kf_done arriving on the same edge the counter hits TIMEOUT → done wins.
- WB, one cycle:
  - Normal completion, no pending clear: write the posterior to the channel memory.
  - Timeout or pending clear: no write.
  - frame_cnt += 1 on both normal and timeout completions.
- OUT: m_valid=1 with m_ch, m_x00, m_x10, m_timeout held stable until m_valid & m_ready; then return to IDLE. s_ready=0 throughout. There is no bypass, so the next accept is possible one cycle after the handshake.
- kf_done=1 in IDLE, LAUNCH, WB or OUT: ignored for data, sets err_spurious.
- clear:
  - Zeroes all channel state the cycle after it is sampled, and clears the sticky flags.
  - If a frame is in flight, set a pending-clear flag. That frame's writeback is suppressed; its result is still output.
  - clear and a write in the same cycle → clear wins.
- Async reset mid-frame: immediate return to IDLE; kf_start and m_valid drop to 0.
- Arithmetic: none. All values are passed bit-exact; there is no saturation and no rounding.

Decomposition:
- kf_pkg holds: the state enum (IDLE..OUT), default N, FRAC and TIMEOUT, and a function computing CHW.
- One sub-module, kf_chan_state_mem:
  - NCH x 2N register file.
  - Asynchronous reset to zero and synchronous clear.
  - One combinational read port and one synchronous write port.
  - Write-then-read in the same cycle returns the old value.

Test Plan:
1. Reset release → s_ready=1, m_valid=0, frame_cnt=0, every sticky flag 0, all kf_* outputs 0.
2. Mock core that raises done 34 cycles after start with post=(0x00123, 0xFFF00); frame on ch0, u00=0x00400 → kf_start high exactly one cycle, one cycle after accept; kf_x_prev=(0,0); m_x=(0x00123, 0xFFF00); last_lat=34; a second ch0 frame shows kf_x00_prev=0x00123.
3. Interleave ch0, ch1, ch0 with the mock returning distinct posts → the ch1 prior is (0,0); the third frame's prior equals the first frame's post; frame_cnt=3.
4. Mock never asserts done → m_valid after 38 WAIT cycles with m_timeout=1, m_x = prior, err_timeout=1, state unchanged. Repeat with done exactly at cycle 38 → a normal result, no error.
5. Hold m_ready=0 for 10 cycles in OUT → m_valid and the data stay stable, s_ready=0, and no kf_start is issued.
6. clear pulsed during WAIT → the frame still outputs but the next prior is (0,0). Send s_ch=5 with NCH=4 → sample dropped, err_badch=1, no kf_start. A stray kf_done in IDLE → err_spurious=1.
